// File: rtl/pipe_pkg.sv
// Shared definitions for the generic pipeline stage register.
//   pipe_st_t : occupancy state of a two-slot (main + skid) stage
//   NOP_INSN  : RV32I NOP (addi x0,x0,0), the default bubble payload
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_st_t;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous reset, active-low (clears cnt)
//   inc : count one event on this edge
//   cnt : current count, sticks at all-ones
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with a 2-entry skid buffer, flush and a
// saturating back-pressure counter.
// Ports:
//   clk       : rising-edge clock
//   rst       : synchronous reset, active-low
//   flush     : discard all held entries this cycle (bubble insertion)
//   in_valid  : upstream offers in_data
//   in_ready  : stage accepts in_data this cycle (registered, plus flush)
//   in_data   : upstream payload
//   out_valid : out_data holds a live entry
//   out_ready : downstream accepts out_data this cycle
//   out_data  : oldest held payload, or BUBBLE when out_valid=0
//   stall_cnt : cycles with out_valid=1 && out_ready=0, saturating
//
// Handshake: a beat transfers on a rising edge where valid and ready are both
// 1 at that edge; a producer holding valid keeps its data stable until the
// transfer, and ready never depends combinationally on the other side's valid
// or ready (in_ready depends only on state and flush).
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                DATA_W = 32,
    parameter logic [DATA_W-1:0] BUBBLE = DATA_W'(NOP_INSN),
    parameter int                CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    pipe_st_t          st, st_nxt;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              acc;
    logic              take;

    // Outputs come straight from registers (plus flush on in_ready), so there
    // is no in->out or out_ready->in_ready combinational path.
    assign in_ready  = (st != ST_FULL) & ~flush;
    assign out_valid = (st != ST_EMPTY);
    assign out_data  = out_valid ? main_q : BUBBLE;

    assign acc  = in_valid & in_ready;
    assign take = out_valid & out_ready;

    always_comb begin
        st_nxt = st;
        main_d = main_q;
        skid_d = skid_q;
        if (flush) begin
            // A take in this cycle is treated as delivered; nothing replays.
            st_nxt = ST_EMPTY;
            main_d = BUBBLE;
            skid_d = BUBBLE;
        end else begin
            case (st)
                ST_EMPTY: begin
                    if (acc) begin
                        main_d = in_data;
                        st_nxt = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (acc && take) begin
                        main_d = in_data;
                    end else if (acc) begin
                        skid_d = in_data;
                        st_nxt = ST_FULL;
                    end else if (take) begin
                        main_d = BUBBLE;
                        st_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only a take can happen.
                    if (take) begin
                        main_d = skid_q;
                        skid_d = BUBBLE;
                        st_nxt = ST_ONE;
                    end
                end
                default: begin
                    st_nxt = ST_EMPTY;
                    main_d = BUBBLE;
                    skid_d = BUBBLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            st     <= ST_EMPTY;
            main_q <= BUBBLE;
            skid_q <= BUBBLE;
        end else begin
            st     <= st_nxt;
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk(clk),
        .rst(rst),
        .inc(out_valid & ~out_ready),
        .cnt(stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed scoreboard bench for pipe_stage_skid (DATA_W=32, CNT_W=4).
module tb_pipe_stage_skid;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  stall_cnt;

    logic [31:0] exp_q[$];
    int          checks   = 0;
    int          failures = 0;

    pipe_stage_skid #(
        .DATA_W(32),
        .BUBBLE(NOP),
        .CNT_W (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .stall_cnt(stall_cnt)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer d until accepted (bounded); the expectation is queued at the
    // negedge before the accepting edge. Leaves in_valid asserted.
    task automatic send(input logic [31:0] d);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                exp_q.push_back(d);
                done = 1'b1;
            end
            step();
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL send_timeout got=not_accepted exp=%h", d);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        step();
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [31:0] e;
        repeat (2) @(posedge clk);
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL mon_unexpected got=%h exp=none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("mon_data", out_data, e);
                end
            end else if (out_valid === 1'b0) begin
                check("mon_bubble", out_data, NOP);
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hDEAD_BEEF;
        out_ready = 1'b0;

        // Reset held two edges with a live offer on the input.
        @(posedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, NOP);
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        step();
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_release_valid", 32'(out_valid), 32'd0);
        step();

        // Streaming 1..8 back-to-back with out_ready=1.
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(i);
            @(negedge clk);
            check("stream_in_ready", 32'(in_ready), 32'd1);
            if (in_ready === 1'b1) exp_q.push_back(32'(i));
            if (i > 1) begin
                check("stream_latency_valid", 32'(out_valid), 32'd1);
                check("stream_latency_data", out_data, 32'(i - 1));
            end
            step();
        end
        in_valid = 1'b0;
        drain();
        check("stream_stall_cnt", 32'(stall_cnt), 32'd0);

        // Back-pressure: A, B fill the stage, C waits.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        @(negedge clk);
        check("bp_a_ready", 32'(in_ready), 32'd1);
        exp_q.push_back(32'hA);
        step();
        in_data = 32'hB;
        @(negedge clk);
        check("bp_b_ready", 32'(in_ready), 32'd1);
        exp_q.push_back(32'hB);
        step();
        in_data = 32'hC;
        @(negedge clk);
        check("bp_full_ready", 32'(in_ready), 32'd0);
        check("bp_head", out_data, 32'hA);
        step();
        step();
        step();
        // Stalled edges: B accept, C refused, plus two more holds.
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_stall_cnt", 32'(stall_cnt), 32'd4);
        step();
        send(32'hC);
        in_valid = 1'b0;
        drain();
        check("bp_stall_cnt_after", 32'(stall_cnt), 32'd4);

        // Flush while FULL with a new offer D present.
        out_ready = 1'b0;
        send(32'h0000_00A2);
        send(32'h0000_00B2);
        in_valid = 1'b1;
        in_data  = 32'h0000_00D0;
        flush    = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("flush_in_ready", 32'(in_ready), 32'd0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_out_data", out_data, NOP);
        check("flush_in_ready_after", 32'(in_ready), 32'd1);
        step();
        out_ready = 1'b1;
        send(32'h0000_00E0);
        in_valid = 1'b0;
        drain();
        repeat (3) @(negedge clk);
        check("flush_no_replay", 32'(out_valid), 32'd0);
        step();

        // Saturation of the 4-bit stall counter.
        reset_pulse();
        out_ready = 1'b0;
        send(32'h0000_0055);
        in_valid = 1'b0;
        repeat (5) step();
        @(negedge clk);
        check("sat_partial", 32'(stall_cnt), 32'd5);
        repeat (20) step();
        @(negedge clk);
        check("sat_max", 32'(stall_cnt), 32'd15);
        repeat (3) step();
        @(negedge clk);
        check("sat_hold", 32'(stall_cnt), 32'd15);
        flush = 1'b1;
        exp_q.delete();
        step();
        flush = 1'b0;
        @(negedge clk);
        check("sat_flush_keeps", 32'(stall_cnt), 32'd15);
        check("sat_flush_empty", 32'(out_valid), 32'd0);
        step();
        reset_pulse();
        @(negedge clk);
        check("sat_rst_clears", 32'(stall_cnt), 32'd0);
        step();

        // Reset and flush together while FULL.
        out_ready = 1'b0;
        send(32'h0000_0111);
        send(32'h0000_0222);
        rst      = 1'b0;
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h0000_0333;
        exp_q.delete();
        step();
        rst      = 1'b1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", out_data, NOP);
        check("midrst_stall_cnt", 32'(stall_cnt), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        step();

        // Recovery after mid-operation reset.
        out_ready = 1'b1;
        send(32'h0000_0444);
        send(32'h0000_0555);
        in_valid = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
